// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: latency classes, counter-width helpers and default latencies shared by the scoreboard files
package hazard_scoreboard_pkg;
  typedef enum logic [1:0] {LAT_NONE, LAT_LOAD, LAT_LONG} lat_class_e;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_LONG_LAT = 4;
  localparam int DEF_FLUSH_CYCLES = 1;
  function automatic int cw_of(input int a, input int b);
    return (a > b ? a : b) > 0 ? $clog2((a > b ? a : b) + 1) : 1;
  endfunction
  function automatic int fw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage hazard bundle; master drives rs1/rs2/wr/valid/load/long/div/mispredict and receives stop_IF/stop_ID
interface hazard_scoreboard_if #(parameter int REG_AW = 5);
  logic [REG_AW-1:0] rs1_ID, rs2_ID, wr_ID;
  logic use_rs1, use_rs2, valid_ID, isLoad_ID, isLong_ID, inst_div, isRiskCtrl;
  logic stop_IF, stop_ID;
  modport master(
    output rs1_ID, rs2_ID, wr_ID, use_rs1, use_rs2, valid_ID, isLoad_ID, isLong_ID, inst_div, isRiskCtrl,
    input stop_IF, stop_ID
  );
  modport slave(
    input rs1_ID, rs2_ID, wr_ID, use_rs1, use_rs2, valid_ID, isLoad_ID, isLong_ID, inst_div, isRiskCtrl,
    output stop_IF, stop_ID
  );
endinterface

// File: rtl/hazard_scoreboard_countdown.sv
// sb_countdown: loadable down counter holding at zero; ports clk, rst, ld, val -> q
module sb_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] val,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (ld) q <= val;
    else if (q != '0) q <= q - W'(1);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID/EX countdown scoreboard for load-use, long-latency and flush stalls; ports clk, rst, bus (hazard_scoreboard_if.slave), perf_stall_cnt, perf_flush_cnt; HAZARD_PERF_EN builds the perf counters
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int LONG_LAT = DEF_LONG_LAT,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
);
  localparam int N = 2 ** REG_AW;
  localparam int CW = cw_of(LOAD_LAT, LONG_LAT);
  localparam int FW = fw_of(FLUSH_CYCLES);
  logic [CW-1:0] pend [N];
  logic [CW-1:0] busy, lat;
  logic [FW-1:0] fcnt;
  logic raw, haz_struct, flush, issue;
  lat_class_e cls;
  always_comb begin
    cls = bus.isLong_ID ? LAT_LONG : bus.isLoad_ID ? LAT_LOAD : LAT_NONE;
    lat = cls == LAT_LONG ? CW'(LONG_LAT) : cls == LAT_LOAD ? CW'(LOAD_LAT) : '0;
    raw = bus.valid_ID & ((bus.use_rs1 & (bus.rs1_ID != '0) & (pend[bus.rs1_ID] != '0)) |
                          (bus.use_rs2 & (bus.rs2_ID != '0) & (pend[bus.rs2_ID] != '0)));
    haz_struct = bus.valid_ID & bus.isLong_ID & (busy != '0);
    flush = bus.isRiskCtrl | (fcnt != '0);
    bus.stop_ID = raw | haz_struct | flush;
    bus.stop_IF = (raw | haz_struct | bus.inst_div) & ~flush;
    issue = bus.valid_ID & ~(raw | haz_struct | flush);
  end
  for (genvar i = 0; i < N; i++) begin : g_pend
    if (i == 0) begin : g_zero
      assign pend[i] = '0;
    end else begin : g_cnt
      sb_countdown #(.W(CW)) u_cnt (
        .clk(clk), .rst(rst), .ld(issue & (bus.wr_ID == REG_AW'(i))), .val(lat), .q(pend[i])
      );
    end
  end
  sb_countdown #(.W(CW)) u_busy (
    .clk(clk), .rst(rst), .ld(issue & bus.isLong_ID), .val(CW'(LONG_LAT)), .q(busy)
  );
  sb_countdown #(.W(FW)) u_flush (
    .clk(clk), .rst(rst), .ld(bus.isRiskCtrl), .val(FW'(FLUSH_CYCLES - 1)), .q(fcnt)
  );
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'((raw | haz_struct) & ~flush);
      perf_flush_cnt <= perf_flush_cnt + 32'(bus.isRiskCtrl);
    end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a ready-time reference model
module tb_hazard_scoreboard;
  localparam int LL = 1;
  localparam int LG = 4;
  localparam int FC = 2;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  hazard_scoreboard_if #(.REG_AW(5)) bus();
  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(LL), .LONG_LAT(LG), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint long_free = 0;
  longint flush_until = 0;
  longint ready [32];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  bit iss;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_clear();
    foreach (ready[r]) ready[r] = 0;
    long_free = 0;
    flush_until = 0;
    m_stall = 0;
    m_flush = 0;
  endtask
  task automatic cycle(output bit issued);
    bit raw, st, fl, sid, sif;
    int lat;
    @(negedge clk);
    raw = bus.valid_ID && ((bus.use_rs1 && bus.rs1_ID != 0 && cyc < ready[bus.rs1_ID]) ||
                           (bus.use_rs2 && bus.rs2_ID != 0 && cyc < ready[bus.rs2_ID]));
    st = bus.valid_ID && bus.isLong_ID && cyc < long_free;
    fl = bus.isRiskCtrl || cyc < flush_until;
    sid = raw || st || fl;
    sif = (raw || st || bus.inst_div) && !fl;
    check("stop_ID", 32'(bus.stop_ID), 32'(sid));
    check("stop_IF", 32'(bus.stop_IF), 32'(sif));
    check("perf_stall", perf_stall_cnt, PERF ? m_stall : 0);
    check("perf_flush", perf_flush_cnt, PERF ? m_flush : 0);
    issued = bus.valid_ID && !sid;
    lat = bus.isLong_ID ? LG : bus.isLoad_ID ? LL : 0;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (issued && bus.wr_ID != 0) ready[bus.wr_ID] = cyc + lat + 1;
      if (issued && bus.isLong_ID) long_free = cyc + LG + 1;
      if (bus.isRiskCtrl) flush_until = cyc + FC;
      if ((raw || st) && !fl) m_stall++;
      if (bus.isRiskCtrl) m_flush++;
    end
    cyc++;
    #1;
  endtask
  task automatic set(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                     input int rd, input bit ld, input bit lg);
    bus.valid_ID = v;
    bus.rs1_ID = 5'(r1);
    bus.rs2_ID = 5'(r2);
    bus.use_rs1 = u1;
    bus.use_rs2 = u2;
    bus.wr_ID = 5'(rd);
    bus.isLoad_ID = ld;
    bus.isLong_ID = lg;
    bus.inst_div = 1'b0;
    bus.isRiskCtrl = 1'b0;
  endtask
  task automatic idle(input int n);
    bit b;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle(b);
  endtask
  task automatic run(input string tag, input int exp_stalls);
    bit b = 0;
    int n = 0;
    for (int k = 0; k < 20 && !b; k++) begin
      cycle(b);
      if (!b) n++;
    end
    check(tag, 32'(n), 32'(exp_stalls));
  endtask
  initial begin
    model_clear();
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    set(1, 0, 0, 0, 0, 5, 1, 0); run("lw_x5", 0);
    set(1, 5, 1, 1, 1, 6, 0, 0); run("load_use", LL);
    set(1, 1, 2, 1, 1, 7, 0, 1); run("div_x7", 0);
    set(1, 7, 1, 1, 1, 9, 0, 0); run("div_use", LG);
    idle(6);
    set(1, 1, 2, 1, 1, 7, 0, 1); run("div_x7_b", 0);
    set(1, 8, 1, 1, 1, 9, 0, 0); run("indep_use", 0);
    idle(6);
    set(1, 1, 2, 1, 1, 10, 0, 1); run("long_a", 0);
    set(1, 1, 2, 1, 1, 11, 0, 1); run("long_struct", LG);
    idle(6);
    set(1, 0, 0, 0, 0, 5, 1, 0); run("lw_x5_b", 0);
    set(1, 5, 1, 1, 1, 6, 0, 0);
    bus.isRiskCtrl = 1'b1;
    cycle(iss);
    check("flush_noissue", 32'(iss), 32'd0);
    bus.isRiskCtrl = 1'b0;
    run("flush_tail", FC - 1);
    set(1, 0, 0, 0, 0, 0, 1, 0); run("lw_x0", 0);
    set(1, 0, 0, 1, 1, 6, 0, 0); run("x0_use", 0);
    idle(6);
    set(1, 1, 2, 1, 1, 5, 0, 1); run("div_x5", 0);
    set(1, 5, 0, 1, 0, 6, 0, 0);
    cycle(iss);
    rst = 1'b1;
    cycle(iss);
    rst = 1'b0;
    run("rst_drop", 0);
    idle(6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    set(1, 0, 0, 0, 0, 5, 1, 0); run("perf_lw", 0);
    set(1, 5, 1, 1, 1, 6, 0, 0); run("perf_use", LL);
    set(0, 0, 0, 0, 0, 0, 0, 0);
    bus.isRiskCtrl = 1'b1;
    cycle(iss);
    idle(2);
    check("perf_stall_dir", perf_stall_cnt, PERF ? 32'd1 : 32'd0);
    check("perf_flush_dir", perf_flush_cnt, PERF ? 32'd1 : 32'd0);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.valid_ID = ($urandom_range(0, 3) != 0);
      bus.rs1_ID = 5'($urandom_range(0, 7));
      bus.rs2_ID = 5'($urandom_range(0, 7));
      bus.use_rs1 = 1'($urandom_range(0, 1));
      bus.use_rs2 = 1'($urandom_range(0, 1));
      bus.wr_ID = 5'($urandom_range(0, 7));
      bus.isLoad_ID = ($urandom_range(0, 2) == 0);
      bus.isLong_ID = ($urandom_range(0, 5) == 0);
      bus.inst_div = ($urandom_range(0, 7) == 0);
      bus.isRiskCtrl = ($urandom_range(0, 11) == 0);
      cycle(iss);
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the combinational pipeline hazard controller. Sits between ID and EX and keeps a per-register countdown scoreboard so it can insert the right number of bubbles for load-use and long-latency (mul/div) results. It also enforces a structural stall on the non-pipelined long-latency unit and stretches control-hazard flushes over a configurable number of cycles. It drives the same hold/clear semantics the pipeline registers already use:
- `stop_IF` holds IF/ID.
- `stop_ID` clears ID/EX.

## Interface
Parameters:
- `REG_AW`, default 5: register index width; the scoreboard has 2^REG_AW entries.
- `LOAD_LAT`, default 1: bubbles needed when a load's consumer follows immediately; 0 means fully forwarded.
- `LONG_LAT`, default 4: bubbles needed by an immediately following consumer of a long-latency result; this is also the occupancy of the long-latency unit.
- `FLUSH_CYCLES`, default 1: number of cycles `stop_ID` stays asserted per mispredict. Must be ≥1.

Ports:
- `clk` in, 1: the block's single clock.
- `rst` in, 1: synchronous, active-high reset.
- `rs1_ID`, `rs2_ID` in, REG_AW: source registers of the instruction in ID.
- `use_rs1`, `use_rs2` in, 1: the ID instruction actually reads rs1/rs2.
- `wr_ID` in, REG_AW: destination register of the ID instruction.
- `valid_ID` in, 1: ID holds a real instruction (not a bubble).
- `isLoad_ID` in, 1: the ID instruction is a load.
- `isLong_ID` in, 1: the ID instruction uses the long-latency unit.
- `inst_div` in, 1: instruction-split request; holds IF only.
- `isRiskCtrl` in, 1: branch mispredict resolved in EX this cycle.
- `stop_IF` out, 1: hold IF/ID.
- `stop_ID` out, 1: clear ID/EX by inserting a bubble.
- `perf_stall_cnt` out, 32: count of stall cycles.
- `perf_flush_cnt` out, 32: count of mispredict events.

## Operation
- State:
  - `pend[r]`: one countdown counter per register, width CW = $clog2(max(LOAD_LAT,LONG_LAT)+1).
  - `busy`: countdown for the long-latency unit, CW bits.
  - `fcnt`: flush countdown, $clog2(FLUSH_CYCLES) bits (minimum 1).
- Combinational hazard terms, computed from registered state only:
  - `raw = valid_ID & ((use_rs1 & rs1_ID!=0 & pend[rs1_ID]!=0) | (use_rs2 & rs2_ID!=0 & pend[rs2_ID]!=0))`
  - `struct = valid_ID & isLong_ID & busy!=0`
  - `flush = isRiskCtrl | fcnt!=0`
- Outputs:
  - `stop_ID = raw | struct | flush`
  - `stop_IF = ((raw | struct) & ~flush) | (inst_div & ~flush)`
  - Flush has priority: IF must accept the redirect PC.
- Issue: `issue = valid_ID & ~stop_ID`.
- Per-cycle update for every r:
  - If `issue` and `r==wr_ID` and `wr_ID!=0`: load `pend[r]` with LONG_LAT if `isLong_ID`, else LOAD_LAT if `isLoad_ID`, else 0.
  - Otherwise, if `pend[r]!=0`, decrement it.
  - A load beats a decrement in the same cycle. `pend[0]` is always 0.
- `busy`: loaded with LONG_LAT on `issue & isLong_ID`; otherwise decrements while nonzero.
- `fcnt`:
  - Loaded with FLUSH_CYCLES-1 when `isRiskCtrl`; otherwise decrements while nonzero.
  - A new `isRiskCtrl` during an active flush reloads it.
- Wrong-path instructions never issue, so a flush never needs to touch the scoreboard.
- `isLoad_ID` and `isLong_ID` both set: treated as long.

## Timing
- Reset: all `pend`, `busy`, `fcnt` and both perf counters clear to 0. `stop_IF`/`stop_ID` are then 0 unless inputs assert them combinationally. Reset mid-stall drops all pending bubbles in the next cycle.
- Outputs are combinational from inputs plus registered state: zero-cycle latency to the pipeline registers.
- Load in ID at cycle t with an immediately dependent instruction: stalls at t+1 … t+LOAD_LAT; the dependent issues at t+LOAD_LAT+1.
- Long op at cycle t: a dependent stalls LONG_LAT cycles. A second long op issues no earlier than t+LONG_LAT+1.
- Mispredict at cycle t: `stop_ID=1` for cycles t … t+FLUSH_CYCLES-1, with `stop_IF=0` throughout.
- WAW (a second writer to the same rd issues while `pend` is nonzero): the counter is overwritten with the new latency.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `perf_stall_cnt` increments each cycle `(raw|struct) & ~flush`.
  - `perf_flush_cnt` increments on each `isRiskCtrl`.
  - Both wrap modulo 2^32 and clear on `rst`.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package:
  - Latency class encoding (NONE/LOAD/LONG).
  - The CW width function.
  - Default values of LOAD_LAT/LONG_LAT/FLUSH_CYCLES.
- One sub-module is natural: `sb_countdown`, a single loadable saturating-at-zero down counter. It is instantiated per register and for `busy`/`fcnt`.

## Test plan
- `lw x5` issues, then `add x6,x5,x1` (LOAD_LAT=1) → exactly 1 cycle of `stop_IF=stop_ID=1`, then the add issues.
- `div x7` (LONG_LAT=4), then `add` using x7 → 4 stall cycles. Dependent on x8 instead → 0 stalls.
- Two back-to-back long ops on independent registers → the second stalls 4 cycles (structural), with both `stop_IF` and `stop_ID` high.
- `isRiskCtrl` during a load-use stall with FLUSH_CYCLES=2 → `stop_ID=1` for 2 cycles, `stop_IF=0`, and no issue until `fcnt==0`.
- `lw x0` followed by a reader of x0 → no stall. `rst` asserted while `pend[x5]==3` → next cycle a reader of x5 issues with no stall.
- With `HAZARD_PERF_EN`: one load-use bubble plus one mispredict → `perf_stall_cnt==1`, `perf_flush_cnt==1`. Without the macro → both remain 0.
